// File: rtl/pulse_peak_detector_if.sv
// Event record channel from the peak detector to the readout logic.
// Valid/ready handshake; the producer holds the record stable until accepted.
interface pulse_peak_detector_if #(
  parameter int DATA_W = 14,
  parameter int TS_W   = 32,
  parameter int WID_W  = 10
);
  logic              evt_valid;
  logic              evt_ready;
  logic [DATA_W-1:0] evt_peak;
  logic [TS_W-1:0]   evt_ts;
  logic [WID_W-1:0]  evt_width;
  logic              evt_sat;

  modport master (
    output evt_valid, evt_peak, evt_ts, evt_width, evt_sat,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_peak, evt_ts, evt_width, evt_sat,
    output evt_ready
  );
endinterface

// File: rtl/pulse_peak_detector.sv
// Finds rising threshold crossings in the shaped stream, tracks each pulse's peak and width,
// and emits one registered record per pulse, followed by a re-arm hold-off.
module pulse_peak_detector #(
  parameter int DATA_W    = 14,
  parameter int TS_W      = 32,
  parameter int HOLDOFF   = 64,
  parameter int MAX_WIDTH = 1023,
  parameter int WID_W     = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic [DATA_W-1:0]      data_i,
  input  logic [DATA_W-1:0]      thr_i,
  pulse_peak_detector_if.master  evt_if,
  output logic [15:0]            drop_cnt_o,
  output logic                   busy_o
);

  localparam int HC_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_e;

  state_e            state_q;
  logic [TS_W-1:0]   ts_q;
  logic              prev_above_q;
  logic [DATA_W-1:0] peak_q;
  logic [TS_W-1:0]   peak_ts_q;
  logic [WID_W-1:0]  width_q;
  logic [HC_W-1:0]   hold_q;
  logic              busy_q;
  logic [15:0]       drop_q;
  logic              evt_valid_q;
  logic [DATA_W-1:0] evt_peak_q;
  logic [TS_W-1:0]   evt_ts_q;
  logic [WID_W-1:0]  evt_width_q;
  logic              evt_sat_q;

  logic              above;
  logic              new_max;
  logic [WID_W-1:0]  width_d;
  logic              emit_d;
  logic              rec_sat_d;
  logic [DATA_W-1:0] rec_peak_d;
  logic [TS_W-1:0]   rec_ts_d;
  logic [WID_W-1:0]  rec_width_d;

  // A saturating pulse includes its final sample, so its record folds that sample in here.
  always_comb begin
    above       = data_i > thr_i;
    new_max     = data_i > peak_q;
    width_d     = width_q + 1'b1;
    emit_d      = 1'b0;
    rec_sat_d   = 1'b0;
    rec_peak_d  = peak_q;
    rec_ts_d    = peak_ts_q;
    rec_width_d = width_q;
    if (state_q == TRACK && enable_i) begin
      if (!above) begin
        emit_d = 1'b1;
      end else if (width_d == WID_W'(MAX_WIDTH)) begin
        emit_d      = 1'b1;
        rec_sat_d   = 1'b1;
        rec_width_d = width_d;
        if (new_max) begin
          rec_peak_d = data_i;
          rec_ts_d   = ts_q;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      ts_q         <= '0;
      prev_above_q <= 1'b1;
      peak_q       <= '0;
      peak_ts_q    <= '0;
      width_q      <= '0;
      hold_q       <= '0;
      busy_q       <= 1'b0;
      drop_q       <= '0;
      evt_valid_q  <= 1'b0;
      evt_peak_q   <= '0;
      evt_ts_q     <= '0;
      evt_width_q  <= '0;
      evt_sat_q    <= 1'b0;
    end else begin
      ts_q         <= ts_q + 1'b1;
      prev_above_q <= above;

      case (state_q)
        IDLE: begin
          if (enable_i && above && !prev_above_q) begin
            state_q   <= TRACK;
            busy_q    <= 1'b1;
            peak_q    <= data_i;
            peak_ts_q <= ts_q;
            width_q   <= WID_W'(1);
          end
        end
        TRACK: begin
          if (!enable_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (emit_d) begin
            state_q <= HOLD;
            hold_q  <= HC_W'(HOLDOFF - 1);
          end else begin
            width_q <= width_d;
            if (new_max) begin
              peak_q    <= data_i;
              peak_ts_q <= ts_q;
            end
          end
        end
        HOLD: begin
          if (hold_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      // An occupied slot that is being drained this cycle can take the new record.
      if (emit_d) begin
        if (!evt_valid_q || evt_if.evt_ready) begin
          evt_valid_q <= 1'b1;
          evt_peak_q  <= rec_peak_d;
          evt_ts_q    <= rec_ts_d;
          evt_width_q <= rec_width_d;
          evt_sat_q   <= rec_sat_d;
        end else if (drop_q != 16'hFFFF) begin
          drop_q <= drop_q + 1'b1;
        end
      end else if (evt_valid_q && evt_if.evt_ready) begin
        evt_valid_q <= 1'b0;
      end
    end
  end

  assign evt_if.evt_valid = evt_valid_q;
  assign evt_if.evt_peak  = evt_peak_q;
  assign evt_if.evt_ts    = evt_ts_q;
  assign evt_if.evt_width = evt_width_q;
  assign evt_if.evt_sat   = evt_sat_q;
  assign drop_cnt_o       = drop_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed bench for pulse_peak_detector: a timestamp-based pulse model is compared
// every cycle, plus hand-computed expectations for each scenario.
module tb_pulse_peak_detector;

  localparam int DATA_W    = 14;
  localparam int TS_W      = 32;
  localparam int HOLDOFF   = 64;
  localparam int MAX_WIDTH = 8;
  localparam int WID_W     = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b1;
  logic [DATA_W-1:0] data = '0;
  logic [DATA_W-1:0] thr = '0;
  logic [15:0]       dropCnt;
  logic              busy;

  int nChecks = 0;
  int nFails  = 0;
  int hsCount = 0;

  pulse_peak_detector_if #(.DATA_W(DATA_W), .TS_W(TS_W), .WID_W(WID_W)) evIf ();

  pulse_peak_detector #(
    .DATA_W(DATA_W), .TS_W(TS_W), .HOLDOFF(HOLDOFF), .MAX_WIDTH(MAX_WIDTH), .WID_W(WID_W)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .enable_i(enable),
    .data_i(data),
    .thr_i(thr),
    .evt_if(evIf.master),
    .drop_cnt_o(dropCnt),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: a pulse is described by its start, running max and width; re-arm is a timestamp deadline.
  longint mTs;
  logic   mPrevAbove, mTracking, mHoldActive;
  longint mHoldEnd;
  int     mPeak, mWidth;
  longint mPeakTs;
  logic   mAbove, mEmit, mSat;
  logic   expValid, expSat, expBusy;
  int     expPeak, expWidth, expDrop;
  longint expTs;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mTs = 0; mPrevAbove = 1'b1; mTracking = 1'b0; mHoldActive = 1'b0; mHoldEnd = 0;
      mPeak = 0; mWidth = 0; mPeakTs = 0;
      expValid = 1'b0; expSat = 1'b0; expBusy = 1'b0;
      expPeak = 0; expWidth = 0; expDrop = 0; expTs = 0;
    end else begin
      mAbove = (int'(data) > int'(thr));
      mEmit  = 1'b0;
      mSat   = 1'b0;
      if (mTracking) begin
        if (!enable) begin
          mTracking = 1'b0;
        end else if (mAbove) begin
          mWidth++;
          if (int'(data) > mPeak) begin
            mPeak = int'(data);
            mPeakTs = mTs;
          end
          if (mWidth == MAX_WIDTH) begin
            mEmit = 1'b1;
            mSat = 1'b1;
          end
        end else begin
          mEmit = 1'b1;
        end
        if (mEmit) begin
          mTracking = 1'b0;
          mHoldActive = 1'b1;
          mHoldEnd = mTs + HOLDOFF;
        end
      end else if (!(mHoldActive && mTs <= mHoldEnd)) begin
        if (enable && mAbove && !mPrevAbove) begin
          mTracking = 1'b1;
          mPeak = int'(data);
          mPeakTs = mTs;
          mWidth = 1;
        end
      end
      if (mEmit) begin
        if (!expValid || evIf.evt_ready) begin
          expValid = 1'b1; expPeak = mPeak; expTs = mPeakTs; expWidth = mWidth; expSat = mSat;
        end else if (expDrop < 65535) begin
          expDrop++;
        end
      end else if (expValid && evIf.evt_ready) begin
        expValid = 1'b0;
      end
      mPrevAbove = mAbove;
      mTs++;
      expBusy = mTracking || (mHoldActive && mTs <= mHoldEnd);
    end
  end

  always @(posedge clk) begin
    if (rst_n && evIf.evt_valid && evIf.evt_ready) hsCount++;
  end

  always @(negedge clk) begin
    checkOutput("evt_valid", 64'(evIf.evt_valid), 64'(expValid));
    if (expValid) begin
      checkOutput("evt_peak", 64'(evIf.evt_peak), 64'(expPeak));
      checkOutput("evt_ts", 64'(evIf.evt_ts), 64'(expTs[TS_W-1:0]));
      checkOutput("evt_width", 64'(evIf.evt_width), 64'(expWidth));
      checkOutput("evt_sat", 64'(evIf.evt_sat), 64'(expSat));
    end
    checkOutput("drop_cnt", 64'(dropCnt), 64'(expDrop));
    checkOutput("busy", 64'(busy), 64'(expBusy));
  end

  task automatic doReset(input int thrVal, input int dataVal, input logic rdy);
    rst_n = 1'b0;
    thr = DATA_W'(thrVal);
    data = DATA_W'(dataVal);
    enable = 1'b1;
    evIf.evt_ready = rdy;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic applyStimulus(input int d, input logic en, input logic rdy);
    data = DATA_W'(d);
    enable = en;
    evIf.evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic runPulse(input int highLen, input int gapLen, input logic rdy);
    for (int i = 0; i < highLen; i++) applyStimulus(200, 1'b1, rdy);
    for (int i = 0; i < gapLen; i++) applyStimulus(0, 1'b1, rdy);
  endtask

  int ramp [8] = '{0, 50, 120, 300, 300, 200, 90, 0};

  initial begin
    evIf.evt_ready = 1'b0;

    // Basic ramp pulse, record held with ready low.
    doReset(100, 0, 1'b0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset valid", 64'(evIf.evt_valid), 64'd0);
    foreach (ramp[i]) applyStimulus(ramp[i], 1'b1, 1'b0);
    checkOutput("ramp valid", 64'(evIf.evt_valid), 64'd1);
    checkOutput("ramp peak", 64'(evIf.evt_peak), 64'd300);
    checkOutput("ramp ts", 64'(evIf.evt_ts), 64'd3);
    checkOutput("ramp width", 64'(evIf.evt_width), 64'd4);
    checkOutput("ramp sat", 64'(evIf.evt_sat), 64'd0);

    // Already above threshold at reset: never triggers.
    doReset(100, 500, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(500, 1'b1, 1'b1);
    checkOutput("const valid", 64'(evIf.evt_valid), 64'd0);
    checkOutput("const busy", 64'(busy), 64'd0);
    checkOutput("const drop", 64'(dropCnt), 64'd0);

    // Saturating pulse, no retrigger after hold-off while still high.
    doReset(10, 0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0);
    for (int i = 0; i < MAX_WIDTH + HOLDOFF + 30; i++) applyStimulus(200, 1'b1, 1'b0);
    checkOutput("sat valid", 64'(evIf.evt_valid), 64'd1);
    checkOutput("sat width", 64'(evIf.evt_width), 64'd8);
    checkOutput("sat flag", 64'(evIf.evt_sat), 64'd1);
    checkOutput("sat peak", 64'(evIf.evt_peak), 64'd200);
    checkOutput("sat ts", 64'(evIf.evt_ts), 64'd1);
    checkOutput("sat drop", 64'(dropCnt), 64'd0);
    checkOutput("sat busy", 64'(busy), 64'd0);

    // Hold-off: 30 apart suppresses the second pulse, 80 apart does not.
    doReset(100, 0, 1'b1);
    hsCount = 0;
    runPulse(0, 2, 1'b1);
    runPulse(3, 27, 1'b1);
    runPulse(3, 100, 1'b1);
    checkOutput("holdoff 30 records", 64'(hsCount), 64'd1);
    runPulse(3, 77, 1'b1);
    runPulse(3, 100, 1'b1);
    checkOutput("holdoff 80 records", 64'(hsCount), 64'd3);

    // Back-pressure: first record held, later ones dropped.
    doReset(100, 0, 1'b0);
    runPulse(0, 2, 1'b0);
    for (int p = 0; p < 3; p++) runPulse(3, 100, 1'b0);
    checkOutput("bp valid", 64'(evIf.evt_valid), 64'd1);
    checkOutput("bp ts", 64'(evIf.evt_ts), 64'd2);
    checkOutput("bp width", 64'(evIf.evt_width), 64'd3);
    checkOutput("bp drop", 64'(dropCnt), 64'd2);
    applyStimulus(0, 1'b1, 1'b1);
    applyStimulus(0, 1'b1, 1'b0);
    checkOutput("bp drained", 64'(evIf.evt_valid), 64'd0);
    checkOutput("bp drop kept", 64'(dropCnt), 64'd2);

    // Enable dropped mid-pulse aborts without a record.
    doReset(100, 0, 1'b1);
    runPulse(0, 2, 1'b1);
    applyStimulus(200, 1'b1, 1'b1);
    applyStimulus(200, 1'b1, 1'b1);
    checkOutput("abort busy before", 64'(busy), 64'd1);
    applyStimulus(200, 1'b0, 1'b1);
    checkOutput("abort busy", 64'(busy), 64'd0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1'b1, 1'b1);
    checkOutput("abort valid", 64'(evIf.evt_valid), 64'd0);

    // Asynchronous reset mid-TRACK with a pending record and a drop recorded.
    doReset(100, 0, 1'b0);
    runPulse(0, 2, 1'b0);
    runPulse(3, 100, 1'b0);
    runPulse(3, 100, 1'b0);
    applyStimulus(200, 1'b1, 1'b0);
    applyStimulus(200, 1'b1, 1'b0);
    checkOutput("pre-reset valid", 64'(evIf.evt_valid), 64'd1);
    checkOutput("pre-reset drop", 64'(dropCnt), 64'd1);
    checkOutput("pre-reset busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async valid", 64'(evIf.evt_valid), 64'd0);
    checkOutput("async busy", 64'(busy), 64'd0);
    checkOutput("async drop", 64'(dropCnt), 64'd0);
    checkOutput("async peak", 64'(evIf.evt_peak), 64'd0);
    checkOutput("async width", 64'(evIf.evt_width), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
